// File: rtl/ntt_mem_ctrl_pkg.sv
// Common constants, FSM encodings and types for the in-place NTT memory sequencer.
`include "defines.vh"

package ntt_mem_ctrl_pkg;

  localparam int DWIDTH     = `DWIDTH;
  localparam int KYBER_N    = `KYBER_N;
  localparam int NTT_LAYERS = `NTT_LAYERS;
  localparam int ZETA_IDX_W = `ZETA_IDX_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_BFW  = 3'd3;
  localparam logic [2:0] S_WRA  = 3'd4;
  localparam logic [2:0] S_WRB  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  typedef struct packed {
    logic [`DWIDTH-1:0] a;
    logic [`DWIDTH-1:0] b;
  } bf_pair_t;

endpackage

// File: rtl/defines.vh
// Shared widths for the NTT datapath; the zeta ROM and the memory sequencer both read these.
`ifndef NTT_DEFINES_VH
`define NTT_DEFINES_VH
`define DWIDTH      16
`define KYBER_N     256
`define NTT_LAYERS  7
`define ZETA_IDX_W  7
`endif

// File: rtl/ntt_mem_ctrl_addr_gen.sv
// Cooley-Tukey schedule counters: len, group base, j and zeta index k.
module ntt_addr_gen
  import ntt_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LAST_LEN   = 2,
  parameter int ZWIDTH     = ZETA_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr_lo,
  output logic [ADDR_WIDTH-1:0] addr_hi,
  output logic [ZWIDTH-1:0]     zeta_idx,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] HALF_N   = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_VAL = ADDR_WIDTH'(LAST_LEN);

  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] grp_base;
  logic [ADDR_WIDTH-1:0] j;
  logic [ZWIDTH-1:0]     k;

  logic [ADDR_WIDTH-1:0] j_next;
  logic [ADDR_WIDTH:0]   next_base;
  logic                  grp_end;
  logic                  layer_end;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    j_next    = j + ADDR_WIDTH'(1);
    next_base = {1'b0, grp_base} + {len, 1'b0};
    grp_end   = (j_next == grp_base + len);
    // The carry out of grp_base + 2*len marks the end of the coefficient array.
    layer_end = grp_end && next_base[ADDR_WIDTH];
    last      = layer_end && (len == LAST_VAL);
    addr_lo   = j;
    addr_hi   = j + len;
    zeta_idx  = k;
  end

  // k wraps to zero after the final group; that value is never presented.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= HALF_N;
      grp_base <= '0;
      j        <= '0;
      k        <= ZWIDTH'(1);
    end else if (init) begin
      len      <= HALF_N;
      grp_base <= '0;
      j        <= '0;
      k        <= ZWIDTH'(1);
    end else if (step) begin
      if (grp_end) begin
        k <= k + ZWIDTH'(1);
        if (layer_end) begin
          len      <= len >> 1;
          grp_base <= '0;
          j        <= '0;
        end else begin
          grp_base <= next_base[ADDR_WIDTH-1:0];
          j        <= next_base[ADDR_WIDTH-1:0];
        end
      end else begin
        j <= j_next;
      end
    end
  end

endmodule

// File: rtl/ntt_mem_ctrl.sv
// In-place NTT sequencer: reads butterfly operand pairs, hands them to the butterfly unit,
// and writes both results back through RAM port A.
module ntt_mem_ctrl
  import ntt_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LAST_LEN   = 2,
  parameter int ZWIDTH     = ZETA_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [`DWIDTH-1:0]    ram_din_a,
  input  logic [`DWIDTH-1:0]    ram_dout_a,
  input  logic [`DWIDTH-1:0]    ram_dout_b,
  output logic                  bf_req,
  output logic [`DWIDTH-1:0]    bf_a,
  output logic [`DWIDTH-1:0]    bf_b,
  output logic [ZWIDTH-1:0]     bf_zeta_idx,
  input  logic                  bf_done,
  input  logic [`DWIDTH-1:0]    bf_a_res,
  input  logic [`DWIDTH-1:0]    bf_b_res
);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr_lo;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic [ZWIDTH-1:0]     zeta_idx;
  logic                  last;
  bf_pair_t              res;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [`DWIDTH-1:0]    din_q;

  ntt_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LAST_LEN   (LAST_LEN),
    .ZWIDTH     (ZWIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     ((state == S_IDLE) && start),
    .step     (state == S_WRB),
    .addr_lo  (addr_lo),
    .addr_hi  (addr_hi),
    .zeta_idx (zeta_idx),
    .last     (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RD;
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = S_BFW;
      S_BFW:   if (bf_done) state_nxt = S_WRA;
      S_WRA:   state_nxt = S_WRB;
      S_WRB:   state_nxt = last ? S_DONE : S_RD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Port signals follow the counters in RD/WRA/WRB and otherwise replay the last driven value.
  always_comb begin
    ram_we     = 1'b0;
    ram_addr_a = addr_a_q;
    ram_addr_b = addr_b_q;
    ram_din_a  = din_q;
    case (state)
      S_RD: begin
        ram_addr_a = addr_lo;
        ram_addr_b = addr_hi;
      end
      S_WRA: begin
        ram_we     = 1'b1;
        ram_addr_a = addr_lo;
        ram_din_a  = res.a;
      end
      S_WRB: begin
        ram_we     = 1'b1;
        ram_addr_a = addr_hi;
        ram_din_a  = res.b;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      din_q    <= '0;
    end else begin
      state    <= state_nxt;
      addr_a_q <= ram_addr_a;
      addr_b_q <= ram_addr_b;
      din_q    <= ram_din_a;
    end
  end

  // Operands, zeta index and bf_req all become visible in the same (first BFW) cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bf_req      <= 1'b0;
      bf_a        <= '0;
      bf_b        <= '0;
      bf_zeta_idx <= '0;
      res         <= '0;
    end else begin
      bf_req <= (state == S_CAP);
      if (state == S_CAP) begin
        bf_a        <= ram_dout_a;
        bf_b        <= ram_dout_b;
        bf_zeta_idx <= zeta_idx;
      end
      if ((state == S_BFW) && bf_done) begin
        res.a <= bf_a_res;
        res.b <= bf_b_res;
      end
    end
  end

endmodule
